// File: rtl/mem_resp_stage.sv
// MEM pipeline stage: holds one EXE payload, waits for its split-transaction SRAM response,
// buffers read data under WB back-pressure and discards responses orphaned by a flush.
module mem_resp_stage #(
  parameter int DW        = 32,
  parameter int EXTRA_W   = 64,
  parameter int MAX_OUTST = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ws_allowin,
  output logic                     ms_allowin,
  input  logic                     es_to_ms_valid,
  input  logic [EXTRA_W+DW+47-1:0] es_to_ms_bus,
  output logic                     ms_to_ws_valid,
  output logic [EXTRA_W+DW+38-1:0] ms_to_ws_bus,
  output logic [DW+7-1:0]          ms_fwd_bus,
  input  logic                     ms_flush_pipe,
  input  logic                     data_sram_data_ok,
  input  logic [DW-1:0]            data_sram_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int AW    = (DW == 64) ? 3 : 2;

  typedef struct packed {
    logic [EXTRA_W-1:0] extra;
    logic               mem_req;
    logic [6:0]         load_op;   // {ld,lwu,lhu,lbu,lw,lh,lb}
    logic               res_from_mem;
    logic               gr_we;
    logic [4:0]         dest;
    logic [DW-1:0]      alu_result;
    logic [31:0]        pc;
  } es_bus_t;

  es_bus_t          bus_in;
  es_bus_t          bus_r;
  logic             ms_valid;
  logic             got;
  logic [DW-1:0]    buf_r;
  logic [CNT_W-1:0] drop_cnt;

  logic orphan_ok;
  logic owned_ok;
  logic ms_ready_go;
  logic flush_inc;
  logic accept;
  logic blk;
  logic fwd_valid;

  assign bus_in = es_to_ms_bus;

  // Orphans always drain first: responses return in request order.
  assign orphan_ok   = data_sram_data_ok && (drop_cnt != '0);
  assign owned_ok    = data_sram_data_ok && (drop_cnt == '0) && ms_valid && bus_r.mem_req && !got;
  assign ms_ready_go = !bus_r.mem_req || got || owned_ok;

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe;
  assign flush_inc      = ms_flush_pipe && ms_valid && bus_r.mem_req && !got && !owned_ok;
  assign accept         = es_to_ms_valid && ms_allowin && !ms_flush_pipe;

  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
      got      <= 1'b0;
      buf_r    <= '0;
      drop_cnt <= '0;
    end else begin
      if (owned_ok) begin
        got   <= 1'b1;
        buf_r <= data_sram_rdata;
      end

      if (ms_flush_pipe) begin
        ms_valid <= 1'b0;
      end else if (accept) begin
        ms_valid <= 1'b1;
        bus_r    <= bus_in;
        got      <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= 1'b0;
      end

      unique case ({flush_inc, orphan_ok})
        2'b10:   drop_cnt <= drop_cnt + CNT_W'(1);
        2'b01:   drop_cnt <= drop_cnt - CNT_W'(1);
        default: drop_cnt <= drop_cnt;
      endcase
    end
  end

  // Same-cycle response is forwarded straight from the SRAM, later cycles from the buffer.
  logic [DW-1:0] rdata_sel;
  logic [AW-1:0] lane;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   lane_w;
  logic [DW-1:0] load_result;
  logic [DW-1:0] final_result;

  assign rdata_sel = got ? buf_r : data_sram_rdata;
  assign lane      = bus_r.alu_result[AW-1:0];
  assign lane_b    = 8'(rdata_sel >> {lane, 3'b000});
  assign lane_h    = 16'(rdata_sel >> {lane[AW-1:1], 4'b0000});
  assign lane_w    = (DW == 64) ? 32'(rdata_sel >> {lane[AW-1], 5'b00000}) : 32'(rdata_sel);

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    load_result = '0;
    if (bus_r.load_op[0])      load_result = DW'(signed'(lane_b));
    else if (bus_r.load_op[1]) load_result = DW'(signed'(lane_h));
    else if (bus_r.load_op[2]) load_result = DW'(signed'(lane_w));
    else if (bus_r.load_op[3]) load_result = DW'(lane_b);
    else if (bus_r.load_op[4]) load_result = DW'(lane_h);
    else if (bus_r.load_op[5]) load_result = (DW == 64) ? DW'(lane_w) : '0;
    else if (bus_r.load_op[6]) load_result = (DW == 64) ? rdata_sel : '0;
  end

  assign final_result = bus_r.res_from_mem ? load_result : bus_r.alu_result;
  assign fwd_valid    = ms_valid && bus_r.gr_we;
  assign blk          = ms_valid && bus_r.res_from_mem && !ms_ready_go;

  assign ms_to_ws_bus = {bus_r.extra, bus_r.gr_we, bus_r.dest, final_result, bus_r.pc};
  assign ms_fwd_bus   = {blk, fwd_valid, bus_r.dest, final_result};

  a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
    !(data_sram_data_ok && !orphan_ok && !owned_ok));

  a_drop_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    int'(drop_cnt) <= MAX_OUTST);

endmodule
